// File: rtl/mod3_pkg.sv
// Shared types and widths for the mod-3 residue arbiter.
// Combinational helpers only; no latency.
// No flow control of its own.
package mod3_pkg;

   localparam int MOD3_W   = 2;
   localparam int WORD_W   = 32;
   localparam int BEATS_W  = 8;
   localparam int ID_MAX_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } mod3_state_e;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [MOD3_W-1:0]   mod;
      logic [BEATS_W-1:0]  beats;
   } mod3_rsp_t;

   function automatic logic [BEATS_W-1:0] sat_inc(input logic [BEATS_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mod3_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Combinational, zero latency.
// No flow control; caller gates the grant.
module mod3_rr_arb #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [N-1:0] hi;
   logic         found;

   always_comb begin
      hi    = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         hi[i] = req[i] && (IW'(i) >= ptr);
      end
      // Lowest request at/after ptr wins, else wrap to lowest overall.
      for (int i = 0; i < N; i++) begin
         if (!found && hi[i]) begin
            found = 1'b1;
            idx   = IW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            found = 1'b1;
            idx   = IW'(i);
         end
      end
      any = |req;
      gnt = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/syn_mod3_32.sv
// Residue of an unsigned WIDTH-bit value modulo 3.
// Purely combinational, zero latency.
// No flow control.
module syn_mod3_32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val,
   output logic [1:0]       res
);

   localparam int PW = WIDTH + (WIDTH % 2);

   logic [PW-1:0] padded;
   logic [2:0]    s;
   logic [1:0]    r;

   // 4 == 1 mod 3, so each 2-bit digit contributes its own value.
   always_comb begin
      padded            = '0;
      padded[WIDTH-1:0] = val;
      s                 = 3'd0;
      r                 = 2'd0;
      for (int i = 0; i < PW / 2; i++) begin
         s = 3'(r) + 3'(padded[2*i +: 2]);
         if (s >= 3'd3) s = s - 3'd3;
         r = s[1:0];
      end
   end

   assign res = r;

endmodule

// File: rtl/mod3_arbiter.sv
// Shares one mod-3 datapath among NREQ packet streams, locking the grant per packet.
// Response registered one cycle after the last beat; one beat per cycle.
// A held response (rsp_valid && !rsp_ready) blocks every req_ready.
module mod3_arbiter
   import mod3_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [NREQ-1:0][WORD_W-1:0]   req_data,
   input  logic [NREQ-1:0]               req_last,
   output logic [NREQ-1:0]               req_ready,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [IDW-1:0]                rsp_id,
   output logic [MOD3_W-1:0]             rsp_mod,
   output logic [BEATS_W-1:0]            rsp_beats
);

   mod3_state_e         state, state_nxt;
   logic [IDW-1:0]      owner, rr_ptr, cur_idx, arb_idx;
   logic [NREQ-1:0]     arb_gnt;
   logic                arb_any, cur_vld, cur_last, stall, xfer;
   logic [WORD_W-1:0]   cur_dat;
   logic [MOD3_W-1:0]   acc, acc_in, word_mod, acc_nxt;
   logic [BEATS_W-1:0]  beats, beats_nxt;
   mod3_rsp_t           rsp_q;

   mod3_rr_arb #(.N(NREQ), .IW(IDW)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign stall = rsp_valid && !rsp_ready;

   always_comb begin
      cur_idx   = (state == LOCK) ? owner : arb_idx;
      cur_vld   = (state == LOCK) ? req_valid[cur_idx] : arb_any;
      cur_dat   = req_data[cur_idx];
      cur_last  = req_last[cur_idx];
      xfer      = cur_vld && !stall;
      acc_in    = (state == LOCK) ? acc : '0;
      beats_nxt = sat_inc((state == LOCK) ? beats : '0);
      req_ready = '0;
      if (rst_n && !stall) begin
         req_ready = (state == LOCK) ? ({{(NREQ-1){1'b0}}, cur_vld} << owner) : arb_gnt;
      end
   end

   syn_mod3_32 #(.WIDTH(WORD_W)) u_word_mod (
      .val (cur_dat),
      .res (word_mod)
   );

   // 2^32 == 1 mod 3, so the running residue folds with each word residue.
   syn_mod3_32 #(.WIDTH(2*MOD3_W)) u_comb_mod (
      .val ({acc_in, word_mod}),
      .res (acc_nxt)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer && !cur_last) state_nxt = LOCK;
         LOCK:    if (xfer && cur_last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_q     <= '0;
         rr_ptr    <= '0;
         owner     <= '0;
         acc       <= '0;
         beats     <= '0;
      end else begin
         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
         if (xfer) begin
            if (cur_last) begin
               rsp_valid   <= 1'b1;
               rsp_q.id    <= ID_MAX_W'(cur_idx);
               rsp_q.mod   <= acc_nxt;
               rsp_q.beats <= beats_nxt;
               rr_ptr      <= (cur_idx == IDW'(NREQ-1)) ? '0 : cur_idx + 1'b1;
               acc         <= '0;
               beats       <= '0;
            end else begin
               owner <= cur_idx;
               acc   <= acc_nxt;
               beats <= beats_nxt;
            end
         end
      end
   end

   assign rsp_id    = IDW'(rsp_q.id);
   assign rsp_mod   = rsp_q.mod;
   assign rsp_beats = rsp_q.beats;

endmodule

// File: tb/tb_mod3_arbiter.sv
// Randomised bench for mod3_arbiter against a big-number residue and round-robin model.
module tb_mod3_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NREQ-1:0]        req_valid, req_last, req_ready;
   logic [NREQ-1:0][31:0]  req_data;
   logic                   rsp_valid, rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [1:0]             rsp_mod;
   logic [7:0]             rsp_beats;

   int vectors     = 0;
   int miscompares = 0;
   int model_ptr   = 0;
   logic [31:0] pkt_q[$];

   mod3_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_mod   (rsp_mod),
      .rsp_beats (rsp_beats)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, need completion");
      $fatal(1, "bench timed out");
   end

   // Residue of the whole big number, MS word first: r = (r*2^32 + w) mod 3.
   function automatic int ref_mod(input logic [31:0] words[$]);
      longint unsigned r = 0;
      foreach (words[i]) r = ((r << 32) + longint'(words[i])) % 3;
      return int'(r);
   endfunction

   function automatic int model_grant(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
      end
      return 0;
   endfunction

   function automatic logic [12:0] rsp_word(input int id, input int m, input int b);
      return {1'b1, 2'(id), 2'(m), 8'(b)};
   endfunction

   // Streams pkt_q on one port; entered and left just after a rising edge.
   task automatic send_pkt(input int id, output bit timeout);
      int cyc;
      timeout = 1'b0;
      for (int b = 0; b < pkt_q.size(); b++) begin
         req_valid[id] = 1'b1;
         req_data[id]  = pkt_q[b];
         req_last[id]  = (b == pkt_q.size() - 1);
         cyc = 0;
         @(negedge clk);
         while (!req_ready[id] && cyc < 50) begin
            @(negedge clk);
            cyc++;
         end
         if (!req_ready[id]) begin
            timeout = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      req_valid[id] = 1'b0;
      req_last[id]  = 1'b0;
      if (!timeout) model_ptr = (id + 1) % NREQ;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_last  = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n  = 1'b1;
      model_ptr = 0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      req_last  = '1;
      req_data  = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_mod, rsp_beats} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_rsp: got v=%0b id=%0d mod=%0d beats=%0d, need all 0",
                  rsp_valid, rsp_id, rsp_mod, rsp_beats);
      end
      vectors++;
      if (req_ready !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ready: got %b, need 0000", req_ready);
      end
      apply_reset();
   endtask

   task automatic test_single();
      bit to;
      pkt_q = {32'h0000_0005};
      send_pkt(0, to);
      @(negedge clk);
      vectors++;
      if (to || {rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(0, 2, 1)) begin
         miscompares++;
         $display("FAIL single_rsp: got v=%0b id=%0d mod=%0d beats=%0d to=%0b, need v=1 id=0 mod=2 beats=1",
                  rsp_valid, rsp_id, rsp_mod, rsp_beats, to);
      end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_clear: got rsp_valid=%0b, need 0", rsp_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_boundary();
      logic [31:0] fixed[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      logic [31:0] w;
      bit to;
      int id, len, exp_m;
      for (int n = 0; n < 27; n++) begin
         w  = (n < 3) ? fixed[n] : $urandom;
         id = $urandom_range(0, NREQ-1);
         pkt_q = {w};
         exp_m = int'(w % 3);
         send_pkt(id, to);
         @(negedge clk);
         vectors++;
         if (to || {rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(id, exp_m, 1)) begin
            miscompares++;
            $display("FAIL word_mod %h: got v=%0b id=%0d mod=%0d beats=%0d, need id=%0d mod=%0d beats=1",
                     w, rsp_valid, rsp_id, rsp_mod, rsp_beats, id, exp_m);
         end
         vectors++;
         if (rsp_mod === 2'd3) begin
            miscompares++;
            $display("FAIL mod_range: got 3, need 0..2");
         end
         @(posedge clk); #1;
      end
      for (int p = 0; p < 12; p++) begin
         len = $urandom_range(1, 6);
         id  = $urandom_range(0, NREQ-1);
         pkt_q.delete();
         for (int b = 0; b < len; b++)
            pkt_q.push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
         exp_m = ref_mod(pkt_q);
         send_pkt(id, to);
         @(negedge clk);
         vectors++;
         if (to || {rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(id, exp_m, len)) begin
            miscompares++;
            $display("FAIL multi_pkt: got v=%0b id=%0d mod=%0d beats=%0d, need id=%0d mod=%0d beats=%0d",
                     rsp_valid, rsp_id, rsp_mod, rsp_beats, id, exp_m, len);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lock();
      bit to;
      pkt_q = {32'd3};
      send_pkt(0, to);
      req_valid[1] = 1'b1; req_data[1] = 32'd2; req_last[1] = 1'b0;
      req_valid[2] = 1'b1; req_data[2] = 32'd7; req_last[2] = 1'b1;
      @(negedge clk);
      vectors++;
      if (to || req_ready !== 4'b0010) begin
         miscompares++;
         $display("FAIL lock_first: got %b, need 0010", req_ready);
      end
      @(posedge clk); #1;
      req_last[1] = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 4'b0010) begin
         miscompares++;
         $display("FAIL lock_hold: got %b, need 0010", req_ready);
      end
      @(posedge clk); #1;
      req_valid[1] = 1'b0; req_last[1] = 1'b0;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(1, 1, 2)) begin
         miscompares++;
         $display("FAIL lock_rsp: got v=%0b id=%0d mod=%0d beats=%0d, need id=1 mod=1 beats=2",
                  rsp_valid, rsp_id, rsp_mod, rsp_beats);
      end
      vectors++;
      if (req_ready !== 4'b0100) begin
         miscompares++;
         $display("FAIL lock_next: got %b, need 0100", req_ready);
      end
      @(posedge clk); #1;
      req_valid[2] = 1'b0; req_last[2] = 1'b0;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(2, 1, 1)) begin
         miscompares++;
         $display("FAIL lock_rq2: got v=%0b id=%0d mod=%0d beats=%0d, need id=2 mod=1 beats=1",
                  rsp_valid, rsp_id, rsp_mod, rsp_beats);
      end
      model_ptr = 3;
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      int g, prev_id, prev_m;
      apply_reset();
      prev_id = 0; prev_m = 0;
      for (int i = 0; i < NREQ; i++) req_data[i] = $urandom;
      req_last  = '1;
      req_valid = '1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         g = model_grant(req_valid);
         vectors++;
         if (req_ready !== 4'(1 << g)) begin
            miscompares++;
            $display("FAIL rr_grant %0d: got %b, need rq%0d", n, req_ready, g);
         end
         if (n > 0) begin
            vectors++;
            if ({rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(prev_id, prev_m, 1)) begin
               miscompares++;
               $display("FAIL rr_rsp %0d: got v=%0b id=%0d mod=%0d, need id=%0d mod=%0d",
                        n, rsp_valid, rsp_id, rsp_mod, prev_id, prev_m);
            end
         end
         @(posedge clk);
         prev_id   = g;
         prev_m    = int'(req_data[g] % 3);
         model_ptr = (g + 1) % NREQ;
         #1 req_data[g] = $urandom;
      end
      req_valid = '0;
      req_last  = '0;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(prev_id, prev_m, 1)) begin
         miscompares++;
         $display("FAIL rr_rsp_last: got v=%0b id=%0d mod=%0d, need id=%0d mod=%0d",
                  rsp_valid, rsp_id, rsp_mod, prev_id, prev_m);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      bit to;
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      rsp_ready = 1'b0;
      pkt_q = {a};
      send_pkt(0, to);
      req_valid[1] = 1'b1; req_data[1] = b; req_last[1] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         vectors++;
         if (to || req_ready !== 4'b0000 ||
             {rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(0, int'(a % 3), 1)) begin
            miscompares++;
            $display("FAIL bp_hold %0d: got ready=%b v=%0b id=%0d mod=%0d beats=%0d, need ready=0000 id=0 mod=%0d beats=1",
                     n, req_ready, rsp_valid, rsp_id, rsp_mod, rsp_beats, a % 3);
         end
         @(posedge clk);
      end
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 4'b0010) begin
         miscompares++;
         $display("FAIL bp_release: got %b, need 0010", req_ready);
      end
      @(posedge clk); #1;
      req_valid[1] = 1'b0; req_last[1] = 1'b0;
      model_ptr = 2;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(1, int'(b % 3), 1)) begin
         miscompares++;
         $display("FAIL bp_next: got v=%0b id=%0d mod=%0d, need id=1 mod=%0d",
                  rsp_valid, rsp_id, rsp_mod, b % 3);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_saturate();
      bit to;
      int id, exp_m;
      id = $urandom_range(0, NREQ-1);
      pkt_q.delete();
      for (int b = 0; b < 300; b++) pkt_q.push_back($urandom);
      exp_m = ref_mod(pkt_q);
      send_pkt(id, to);
      @(negedge clk);
      vectors++;
      if (to || {rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(id, exp_m, 255)) begin
         miscompares++;
         $display("FAIL sat_beats: got v=%0b id=%0d mod=%0d beats=%0d, need id=%0d mod=%0d beats=255",
                  rsp_valid, rsp_id, rsp_mod, rsp_beats, id, exp_m);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit to;
      int cyc;
      to = 1'b0;
      for (int b = 0; b < 3; b++) begin
         req_valid[3] = 1'b1; req_data[3] = $urandom; req_last[3] = 1'b0;
         cyc = 0;
         @(negedge clk);
         while (!req_ready[3] && cyc < 50) begin
            @(negedge clk);
            cyc++;
         end
         if (!req_ready[3]) to = 1'b1;
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (to || req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid: got ready=%b v=%0b, need ready=0000 v=0", req_ready, rsp_valid);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_ptr = 0;
      req_valid[0] = 1'b1; req_last[0] = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_ptr: got ready=%b v=%0b, need ready=0001 v=0", req_ready, rsp_valid);
      end
      req_valid = '0;
      req_last  = '0;
      @(posedge clk); #1;
      pkt_q = {32'd1, 32'd1, 32'd1};
      send_pkt(3, to);
      @(negedge clk);
      vectors++;
      if (to || {rsp_valid, rsp_id, rsp_mod, rsp_beats} !== rsp_word(3, 0, 3)) begin
         miscompares++;
         $display("FAIL rst_fresh: got v=%0b id=%0d mod=%0d beats=%0d, need id=3 mod=0 beats=3",
                  rsp_valid, rsp_id, rsp_mod, rsp_beats);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundary();
      test_lock();
      test_round_robin();
      test_backpressure();
      test_saturate();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
